// File: rtl/normalize_sequencer.sv
// Post-add normalizer: a one-step right shift for an add carry, or repeated left shifts
// until the hidden bit is set. Exponent overflow and underflow are flagged.
module normalize_sequencer #(
    parameter int MANT_W = 12,
    parameter int EXP_W  = 5
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              startValid,
    output logic              ready,
    input  logic [MANT_W-1:0] mantIn,
    input  logic [EXP_W-1:0]  expIn,
    input  logic              flush,
    output logic              doneValid,
    input  logic              doneReady,
    output logic [MANT_W-1:0] mantOut,
    output logic [EXP_W-1:0]  expOut,
    output logic              overflow,
    output logic              underflow
);

    typedef enum logic [1:0] {IDLE, RIGHT, LEFT, DONE} state_t;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

    state_t            state_q, state_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              op_sel;
    logic              cin;
    logic [EXP_W-1:0]  exp_adj;
    logic [MANT_W-1:0] mant_shl;

    // Single adder for all exponent updates: op_sel=1 adds all-ones (-1), cin supplies +1.
    assign exp_adj  = exp_q + (op_sel ? EXP_ONES : '0) + {{(EXP_W-1){1'b0}}, cin};
    assign mant_shl = {mant_q[MANT_W-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        mant_d  = mant_q;
        exp_d   = exp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        op_sel  = 1'b0;
        cin     = 1'b0;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startValid) begin
                        mant_d = mantIn;
                        exp_d  = expIn;
                        ovf_d  = 1'b0;
                        unf_d  = 1'b0;
                        if (mantIn == '0) begin
                            mant_d  = '0;
                            exp_d   = '0;
                            state_d = DONE;
                        end else if (mantIn[MANT_W-1]) begin
                            state_d = RIGHT;
                        end else if (mantIn[MANT_W-2] || (expIn == '0)) begin
                            state_d = DONE;
                        end else begin
                            state_d = LEFT;
                        end
                    end
                end
                RIGHT: begin
                    op_sel  = 1'b0;
                    cin     = 1'b1;
                    state_d = DONE;
                    if (exp_adj == EXP_ONES) begin
                        ovf_d  = 1'b1;
                        mant_d = '0;
                        exp_d  = EXP_ONES;
                    end else begin
                        mant_d = mant_q >> 1;
                        exp_d  = exp_adj;
                    end
                end
                LEFT: begin
                    op_sel = 1'b1;
                    cin    = 1'b0;
                    // Exponent 1 cannot go lower without reaching the zero/denormal code.
                    if (exp_q == EXP_ONE) begin
                        exp_d   = '0;
                        unf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        mant_d = mant_shl;
                        exp_d  = exp_adj;
                        if (mant_shl[MANT_W-2]) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (doneReady) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            mant_q  <= '0;
            exp_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            exp_q   <= exp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign doneValid = (state_q == DONE);
    assign mantOut   = mant_q;
    assign expOut    = exp_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_normalize_sequencer.sv
// Directed-vector bench for normalize_sequencer, with expected values worked out by hand.
module tb_normalize_sequencer;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startValid;
    logic        ready;
    logic [11:0] mantIn;
    logic [4:0]  expIn;
    logic        flush;
    logic        doneValid;
    logic        doneReady;
    logic [11:0] mantOut;
    logic [4:0]  expOut;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    normalize_sequencer #(.MANT_W(12), .EXP_W(5)) dut (
        .clk(clk), .resetN(resetN), .startValid(startValid), .ready(ready),
        .mantIn(mantIn), .expIn(expIn), .flush(flush), .doneValid(doneValid),
        .doneReady(doneReady), .mantOut(mantOut), .expOut(expOut),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Called 1 time unit after an edge while the block is idle. lat counts edges from accept to doneValid.
    task automatic do_request(input logic [11:0] m, input logic [4:0] e, output int lat);
        mantIn = m;
        expIn = e;
        startValid = 1'b1;
        @(posedge clk); #1;
        startValid = 1'b0;
        lat = 1;
        while (!doneValid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        doneReady = 1'b1;
        @(posedge clk); #1;
        doneReady = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        startValid = 1'b0; flush = 1'b0; doneReady = 1'b0;
        mantIn = '0; expIn = '0;
        #3;
        checks++;
        if (ready !== 1'b1 || doneValid !== 1'b0 || mantOut !== 12'h000 || expOut !== 5'd0 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b dv=%b m=%h e=%0d o=%b u=%b want 1 0 000 0 0 0",
                     ready, doneValid, mantOut, expOut, overflow, underflow);
        end
        @(negedge clk); resetN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_direct();
        int lat;
        do_request(12'h400, 5'd15, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL direct_latency got %0d want 1", lat); end
        checks++;
        if (mantOut !== 12'h400 || expOut !== 5'd15 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL direct_result got m=%h e=%0d o=%b u=%b want 400 15 0 0", mantOut, expOut, overflow, underflow);
        end
        release_result();
        checks++;
        if (ready !== 1'b1 || doneValid !== 1'b0) begin
            errors++; $display("FAIL direct_release got rdy=%b dv=%b want 1 0", ready, doneValid);
        end
    endtask

    task automatic test_right();
        int lat;
        do_request(12'h800, 5'd15, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL right_latency got %0d want 2", lat); end
        checks++;
        if (mantOut !== 12'h400 || expOut !== 5'd16 || overflow !== 1'b0) begin
            errors++; $display("FAIL right_result got m=%h e=%0d o=%b want 400 16 0", mantOut, expOut, overflow);
        end
        release_result();
    endtask

    task automatic test_overflow();
        int lat;
        do_request(12'h800, 5'd30, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL ovf_latency got %0d want 2", lat); end
        checks++;
        if (mantOut !== 12'h000 || expOut !== 5'd31 || overflow !== 1'b1 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_result got m=%h e=%0d o=%b u=%b want 000 31 1 0", mantOut, expOut, overflow, underflow);
        end
        release_result();
        checks++;
        if (overflow !== 1'b1 || expOut !== 5'd31) begin
            errors++; $display("FAIL ovf_idle_hold got o=%b e=%0d want 1 31", overflow, expOut);
        end
        do_request(12'h500, 5'd7, lat);
        checks++;
        if (lat !== 1 || overflow !== 1'b0 || mantOut !== 12'h500 || expOut !== 5'd7) begin
            errors++;
            $display("FAIL ovf_cleared got lat=%0d o=%b m=%h e=%0d want 1 0 500 7", lat, overflow, mantOut, expOut);
        end
        release_result();
    endtask

    task automatic test_left();
        int lat;
        do_request(12'h001, 5'd20, lat);
        checks++;
        if (lat !== 11) begin errors++; $display("FAIL left_latency got %0d want 11", lat); end
        checks++;
        if (mantOut !== 12'h400 || expOut !== 5'd10 || underflow !== 1'b0) begin
            errors++; $display("FAIL left_result got m=%h e=%0d u=%b want 400 10 0", mantOut, expOut, underflow);
        end
        release_result();
    endtask

    task automatic test_underflow();
        int lat;
        do_request(12'h010, 5'd3, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL unf_latency got %0d want 4", lat); end
        checks++;
        if (mantOut !== 12'h040 || expOut !== 5'd0 || underflow !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL unf_result got m=%h e=%0d u=%b o=%b want 040 0 1 0", mantOut, expOut, underflow, overflow);
        end
        release_result();
    endtask

    task automatic test_zero_and_exp0();
        int lat;
        do_request(12'h000, 5'd7, lat);
        checks++;
        if (lat !== 1 || mantOut !== 12'h000 || expOut !== 5'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL zero_mant got lat=%0d m=%h e=%0d u=%b want 1 000 0 0", lat, mantOut, expOut, underflow);
        end
        release_result();
        do_request(12'h100, 5'd0, lat);
        checks++;
        if (lat !== 1 || mantOut !== 12'h100 || expOut !== 5'd0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL exp_zero got lat=%0d m=%h e=%0d u=%b want 1 100 0 0", lat, mantOut, expOut, underflow);
        end
        release_result();
    endtask

    task automatic test_hold();
        int lat;
        do_request(12'h800, 5'd15, lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (doneValid !== 1'b1 || mantOut !== 12'h400 || expOut !== 5'd16 || ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d got dv=%b m=%h e=%0d rdy=%b want 1 400 16 0",
                         i, doneValid, mantOut, expOut, ready);
            end
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        do_request(12'h400, 5'd15, lat);
        doneReady = 1'b1;
        startValid = 1'b1;
        mantIn = 12'h600;
        expIn = 5'd9;
        @(posedge clk); #1;
        doneReady = 1'b0;
        checks++;
        if (ready !== 1'b1 || doneValid !== 1'b0 || mantOut !== 12'h400) begin
            errors++;
            $display("FAIL b2b_no_accept got rdy=%b dv=%b m=%h want 1 0 400", ready, doneValid, mantOut);
        end
        @(posedge clk); #1;
        startValid = 1'b0;
        checks++;
        if (doneValid !== 1'b1 || mantOut !== 12'h600 || expOut !== 5'd9) begin
            errors++;
            $display("FAIL b2b_next_accept got dv=%b m=%h e=%0d want 1 600 9", doneValid, mantOut, expOut);
        end
        release_result();
    endtask

    task automatic test_flush();
        logic seen;
        mantIn = 12'h001; expIn = 5'd20; startValid = 1'b1;
        @(posedge clk); #1;
        startValid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (ready !== 1'b1 || doneValid !== 1'b0) begin
            errors++; $display("FAIL flush_left got rdy=%b dv=%b want 1 0", ready, doneValid);
        end
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (doneValid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_done got dv_seen=%b want 0", seen); end
        flush = 1'b1; startValid = 1'b1; mantIn = 12'h400; expIn = 5'd15;
        @(posedge clk); #1;
        flush = 1'b0; startValid = 1'b0;
        checks++;
        if (ready !== 1'b1 || doneValid !== 1'b0) begin
            errors++; $display("FAIL flush_over_accept got rdy=%b dv=%b want 1 0", ready, doneValid);
        end
    endtask

    task automatic test_reset_mid();
        mantIn = 12'h001; expIn = 5'd20; startValid = 1'b1;
        @(posedge clk); #1;
        startValid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetN = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || doneValid !== 1'b0 || mantOut !== 12'h000 || expOut !== 5'd0 ||
            overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%b dv=%b m=%h e=%0d o=%b u=%b want 1 0 000 0 0 0",
                     ready, doneValid, mantOut, expOut, overflow, underflow);
        end
        @(negedge clk);
        resetN = 1'b1;
        mantIn = 12'h400; expIn = 5'd15; startValid = 1'b1;
        @(posedge clk); #1;
        startValid = 1'b0;
        checks++;
        if (doneValid !== 1'b1 || mantOut !== 12'h400 || expOut !== 5'd15) begin
            errors++;
            $display("FAIL reset_first_accept got dv=%b m=%h e=%0d want 1 400 15", doneValid, mantOut, expOut);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_direct();
        test_right();
        test_overflow();
        test_left();
        test_underflow();
        test_zero_and_exp0();
        test_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/normalize_sequencer.md
NORMALIZE_SEQUENCER -- requirements
Module: normalize_sequencer

Interface
REQ-001 SHALL have parameter MANT_W, default 12, mantissa width: bit MANT_W-1 is the add carry, bit MANT_W-2 is the hidden bit, the rest are fraction.
REQ-002 SHALL have parameter EXP_W, default 5, biased exponent width; the all-ones exponent encodes infinity.
REQ-003 SHALL have one clock and asynchronous active-low reset; ports in order: clk (in, 1, rising-edge clock), resetN (in, 1, async active-low reset).
REQ-004 SHALL have port startValid (in, 1): a request is present.
REQ-005 SHALL have port ready (out, 1): the block accepts a request this cycle.
REQ-006 SHALL have port mantIn (in, MANT_W): raw adder mantissa.
REQ-007 SHALL have port expIn (in, EXP_W): pre-normalization exponent.
REQ-008 SHALL have port flush (in, 1): synchronous abort.
REQ-009 SHALL have port doneValid (out, 1): the result is valid.
REQ-010 SHALL have port doneReady (in, 1): the consumer accepts the result.
REQ-011 SHALL have ports mantOut (out, MANT_W), expOut (out, EXP_W), overflow (out, 1) and underflow (out, 1).

Function
REQ-012 SHALL implement FSM states IDLE, RIGHT, LEFT and DONE; ready=1 only in IDLE.
REQ-013 SHALL accept a request when startValid&&ready, registering mantIn and expIn on that edge.
REQ-014 SHALL select the next state on accept: mantIn==0 -> DONE with mant=0, exp=0; mantIn[MANT_W-1]=1 -> RIGHT; mantIn[MANT_W-2]=1 or expIn==0 -> DONE unchanged; else -> LEFT.
REQ-015 SHALL perform all exponent arithmetic on one shared incrementer/decrementer: increment = operationSelect 0, carryIn 1; decrement = operationSelect 1, carryIn 0; no second adder.
REQ-016 SHALL, in RIGHT (one cycle), shift mant right by 1 (LSB dropped) and increment exp.
REQ-017 SHALL, in RIGHT, set overflow=1, mant=0 and exp=all-ones when the incremented exp equals all-ones; the FSM then goes to DONE.
REQ-018 SHALL, in LEFT, each cycle: if exp==1, set exp=0 and underflow=1 with no shift, and go to DONE.
REQ-019 SHALL, in LEFT when exp!=1, shift mant left by 1, decrement exp, and go to DONE when the shifted mant[MANT_W-2]==1; otherwise stay in LEFT.
REQ-020 SHALL give latency, in edges from the accept edge to doneValid high: 1 for the direct-DONE path, 2 for RIGHT, k+1 for k left shifts, and k+2 for an underflow exit after k shifts.
REQ-021 SHALL, in DONE, assert doneValid and hold mantOut, expOut, overflow and underflow stable until doneReady=1; then go to IDLE on the same edge.
REQ-022 SHALL NOT accept a new request in the cycle doneReady completes; the earliest accept is the following cycle.
REQ-023 SHALL clear overflow and underflow on each accept.
REQ-024 SHALL, on flush=1 in any state, go to IDLE at the next edge with no doneValid; flush has priority over accept and doneReady.
REQ-025 SHALL keep mantOut, expOut and the flags at their last values in IDLE.

Reset
REQ-026 SHALL, on resetN=0, immediately and asynchronously force state IDLE, ready=1, doneValid=0, mantOut=0, expOut=0, overflow=0 and underflow=0, including mid-operation.
REQ-027 SHALL, after resetN deasserts, first accept a request on the first rising edge with startValid=1.

Verification
REQ-028 SHALL verify: mantIn=0x400, expIn=15 -> doneValid at latency 1, mantOut=0x400, expOut=15, flags 0.
REQ-029 SHALL verify: mantIn=0x800, expIn=15 -> latency 2, mantOut=0x400, expOut=16.
REQ-030 SHALL verify: mantIn=0x800, expIn=30 -> latency 2, overflow=1, mantOut=0, expOut=31.
REQ-031 SHALL verify: mantIn=0x001, expIn=20 -> latency 11, mantOut=0x400, expOut=10.
REQ-032 SHALL verify: mantIn=0x010, expIn=3 -> latency 4, mantOut=0x040, expOut=0, underflow=1.
REQ-033 SHALL verify: doneReady held 0 for 5 cycles, outputs stable; flush in LEFT -> IDLE next edge, doneValid never asserted; resetN pulsed low in LEFT -> all outputs 0 and ready=1 immediately.
